// File: rtl/icache_line_adapter_if.sv
// Line-fill (cache side) and burst-read (memory side) signal bundle for icache_line_adapter.
// The slave modport is the adapter's view; the master modport is the surrounding cache/memory view.
interface icache_line_adapter_if #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
);
    logic [31:0]       pmem_address;
    logic              pmem_read;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;
    logic [31:0]       mem_address;
    logic              mem_read;
    logic              mem_gnt;
    logic [BEAT_W-1:0] mem_rdata;
    logic              mem_rvalid;

    modport slave (
        input  pmem_address, pmem_read, mem_gnt, mem_rdata, mem_rvalid,
        output pmem_rdata, pmem_resp, mem_address, mem_read
    );

    modport master (
        output pmem_address, pmem_read, mem_gnt, mem_rdata, mem_rvalid,
        input  pmem_rdata, pmem_resp, mem_address, mem_read
    );
endinterface

// File: rtl/icache_line_adapter.sv
// Packs a line-aligned burst of BEAT_W beats into one LINE_W cache line and returns it with a one-cycle pmem_resp.
// Optional same-line replay buffer enabled by defining ICACHE_ADAPTER_LINE_BUF_EN.
module icache_line_adapter #(
    parameter int LINE_W = 256,
    parameter int BEAT_W = 64
) (
    input logic                  clk,
    input logic                  rst,
    icache_line_adapter_if.slave bus
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int OFS   = $clog2(LINE_W / 8);
    localparam int CNT_W = $clog2(BEATS);
    localparam int TAG_W = 32 - OFS;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        BURST = 3'd2,
        RESP  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nxt_s;
    logic [TAG_W-1:0]  addr_r;
    logic [LINE_W-1:0] line_r;
    logic [CNT_W-1:0]  beat_cnt_r;
    logic [TAG_W-1:0]  req_tag_s;

    assign req_tag_s = bus.pmem_address[31:OFS];

`ifdef ICACHE_ADAPTER_LINE_BUF_EN
    logic [TAG_W-1:0] last_addr_r;
    logic             last_vld_r;
    logic             buf_hit_s;

    assign buf_hit_s = last_vld_r && (req_tag_s == last_addr_r);
`endif

    // All outputs come from registers or the state decode, never from mem_* inputs.
    assign bus.mem_read    = (state_r == REQ);
    assign bus.pmem_resp   = (state_r == RESP);
    assign bus.mem_address = {addr_r, {OFS{1'b0}}};
    assign bus.pmem_rdata  = line_r;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.pmem_read) begin
`ifdef ICACHE_ADAPTER_LINE_BUF_EN
                    if (buf_hit_s) begin
                        state_nxt_s = RESP;
                    end else begin
                        state_nxt_s = REQ;
                    end
`else
                    state_nxt_s = REQ;
`endif
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                if (bus.mem_gnt) begin
                    state_nxt_s = BURST;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            BURST: begin
                if (bus.mem_rvalid && (beat_cnt_r == LAST_BEAT)) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = BURST;
                end
            end
            RESP: begin
                state_nxt_s = DONE;
            end
            DONE: begin
                // The cache may keep asking for the same line while its tags update.
                if (!bus.pmem_read || (req_tag_s != addr_r)) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Address latch, beat counter and line assembly; beats outside REQ/BURST are dropped.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_r     <= '0;
            line_r     <= '0;
            beat_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.pmem_read) begin
                        addr_r <= req_tag_s;
                    end
                end
                REQ: begin
                    if (bus.mem_gnt) begin
                        if (bus.mem_rvalid) begin
                            line_r[BEAT_W-1:0] <= bus.mem_rdata;
                            beat_cnt_r         <= CNT_W'(1);
                        end else begin
                            beat_cnt_r <= '0;
                        end
                    end
                end
                BURST: begin
                    if (bus.mem_rvalid) begin
                        line_r[beat_cnt_r*BEAT_W +: BEAT_W] <= bus.mem_rdata;
                        beat_cnt_r                          <= beat_cnt_r + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef ICACHE_ADAPTER_LINE_BUF_EN
    // Remember the most recently returned line address for same-line replays.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_addr_r <= '0;
            last_vld_r  <= 1'b0;
        end else if (state_r == RESP) begin
            last_addr_r <= addr_r;
            last_vld_r  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_line_adapter.sv
// Scoreboard bench for icache_line_adapter: stimulus pushes expected bursts/lines, a negedge monitor pops and compares.
module tb_icache_line_adapter;
    typedef struct {
        logic [255:0] data;
        int           cyc;
    } resp_t;

`ifdef ICACHE_ADAPTER_LINE_BUF_EN
    localparam bit LB_EN = 1'b1;
`else
    localparam bit LB_EN = 1'b0;
`endif
    localparam logic [63:0] STRAY = 64'hBAD0_BAD1_BAD2_BAD3;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   errors = 0;

    resp_t        exp_resp_q[$];
    logic [31:0]  exp_addr_q[$];
    logic         exp_mem_read = 1'b0;
    logic         chk_zero = 1'b0;
    logic         chk_end = 1'b0;
    logic [255:0] shadow_line = '0;
    resp_t        mon_r;
    logic [31:0]  mon_a;

    icache_line_adapter_if #(.LINE_W(256), .BEAT_W(64)) bus ();

    icache_line_adapter #(.LINE_W(256), .BEAT_W(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rep8(input logic [7:0] b);
        return {8{b}};
    endfunction

    // Monitor: all comparisons happen here, mid-cycle on the falling edge.
    always @(negedge clk) begin
        tests++;
        if (bus.mem_read !== exp_mem_read) begin
            errors++;
            $display("FAIL mem_read cyc=%0d got=%b want=%b", cyc, bus.mem_read, exp_mem_read);
        end
        if (bus.mem_read === 1'b1 && bus.mem_gnt === 1'b1) begin
            tests++;
            if (exp_addr_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_burst cyc=%0d got=%h want=none", cyc, bus.mem_address);
            end else begin
                mon_a = exp_addr_q.pop_front();
                if (bus.mem_address !== mon_a) begin
                    errors++;
                    $display("FAIL mem_address cyc=%0d got=%h want=%h", cyc, bus.mem_address, mon_a);
                end
            end
        end
        if (bus.pmem_resp !== 1'b0) begin
            tests++;
            if (exp_resp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_resp cyc=%0d got=%b want=0", cyc, bus.pmem_resp);
            end else begin
                mon_r = exp_resp_q.pop_front();
                if (bus.pmem_rdata !== mon_r.data || cyc != mon_r.cyc) begin
                    errors++;
                    $display("FAIL resp cyc=%0d want_cyc=%0d got=%h want=%h", cyc, mon_r.cyc, bus.pmem_rdata, mon_r.data);
                end
            end
        end
        if (chk_zero) begin
            tests++;
            if (bus.pmem_rdata !== '0 || bus.pmem_resp !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_address !== 32'h0) begin
                errors++;
                $display("FAIL reset_outputs cyc=%0d got rdata=%h resp=%b rd=%b addr=%h want all zero",
                         cyc, bus.pmem_rdata, bus.pmem_resp, bus.mem_read, bus.mem_address);
            end
        end
        if (chk_end) begin
            tests++;
            if (exp_resp_q.size() != 0 || exp_addr_q.size() != 0) begin
                errors++;
                $display("FAIL pending got resp=%0d bursts=%0d want 0 0", exp_resp_q.size(), exp_addr_q.size());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One line request: cycle 0 is the first IDLE cycle with pmem_read high.
    task automatic fill(input logic [31:0] addr, input logic [31:0] maddr, input logic [255:0] line,
                        input int gc, input int b0, input int b1, input int b2, input int b3,
                        input int hold, input logic burst, input logic chain, input logic [31:0] next_addr);
        int    t0;
        int    last;
        resp_t r;
        t0 = cyc;
        bus.pmem_address = addr;
        bus.pmem_read    = 1'b1;
        if (burst) begin
            exp_addr_q.push_back(maddr);
            r.data      = line;
            last        = b3 + 1;
            shadow_line = line;
        end else begin
            r.data = shadow_line;
            last   = 1;
        end
        r.cyc = t0 + last;
        exp_resp_q.push_back(r);
        for (int c = 0; c <= last + hold; c++) begin
            bus.mem_gnt    = burst && (c == gc);
            exp_mem_read   = burst && (c >= 1) && (c <= gc);
            bus.mem_rvalid = 1'b0;
            bus.mem_rdata  = STRAY;
            if (burst) begin
                if (c == b0) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = line[63:0];    end
                if (c == b1) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = line[127:64];  end
                if (c == b2) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = line[191:128]; end
                if (c == b3) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = line[255:192]; end
            end
            step();
        end
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        exp_mem_read   = 1'b0;
        if (chain) begin
            bus.pmem_address = next_addr;
        end else begin
            bus.pmem_read = 1'b0;
        end
        step();
    endtask

    initial begin
        logic [255:0] la, lb, lc, ld, le, lf;
        la = {rep8(8'h44), rep8(8'h33), rep8(8'h22), rep8(8'h11)};
        lb = {rep8(8'hD4), rep8(8'hC3), rep8(8'hB2), rep8(8'hA1)};
        lc = {64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000, 64'h5A5A_5A5A_A5A5_A5A5, 64'h0000_0000_0000_0001};
        ld = {rep8(8'h88), rep8(8'h77), rep8(8'h66), rep8(8'h55)};
        le = {rep8(8'hEE), rep8(8'hDD), rep8(8'hCC), rep8(8'hBB)};
        lf = {rep8(8'h0F), rep8(8'h0E), rep8(8'h0D), rep8(8'h0C)};

        rst = 1'b0;
        bus.pmem_address = 32'h0;
        bus.pmem_read    = 1'b0;
        bus.mem_gnt      = 1'b0;
        bus.mem_rdata    = 64'h0;
        bus.mem_rvalid   = 1'b0;
        repeat (2) step();
        chk_zero = 1'b1;
        step();
        chk_zero = 1'b0;
        rst = 1'b1;
        repeat (2) step();

        // Basic fill, gapped beats with late grant, beat 0 in the grant cycle.
        fill(32'h0000_0064, 32'h0000_0060, la, 1, 2, 3, 4, 5, 0, 1'b1, 1'b0, 32'h0);
        step();
        fill(32'h0000_0100, 32'h0000_0100, lb, 4, 5, 8, 9, 12, 0, 1'b1, 1'b0, 32'h0);
        step();
        fill(32'h0000_01FF, 32'h0000_01E0, lc, 2, 2, 3, 4, 5, 0, 1'b1, 1'b0, 32'h0);
        step();

        // Held request: three extra cycles of the same address, then a fresh line.
        fill(32'h0000_0040, 32'h0000_0040, ld, 1, 2, 3, 4, 5, 3, 1'b1, 1'b0, 32'h0);
        step();
        fill(32'h0000_0080, 32'h0000_0080, le, 1, 2, 3, 4, 5, 0, 1'b1, 1'b0, 32'h0);
        step();

        // Back-to-back lines: address switches while the adapter sits in DONE.
        fill(32'h0000_0060, 32'h0000_0060, lf, 1, 2, 3, 4, 5, 0, 1'b1, 1'b1, 32'h0000_00A0);
        fill(32'h0000_00A0, 32'h0000_00A0, la, 3, 4, 6, 7, 9, 0, 1'b1, 1'b0, 32'h0);
        step();

        // Reset during BURST after beat 1, then stray beats.
        bus.pmem_address = 32'h0000_0200;
        bus.pmem_read    = 1'b1;
        exp_addr_q.push_back(32'h0000_0200);
        step();
        exp_mem_read = 1'b1;
        bus.mem_gnt  = 1'b1;
        step();
        exp_mem_read   = 1'b0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rep8(8'h91);
        step();
        bus.mem_rdata = rep8(8'h92);
        step();
        bus.mem_rvalid = 1'b0;
        bus.pmem_read  = 1'b0;
        rst            = 1'b0;
        chk_zero       = 1'b1;
        shadow_line    = '0;
        step();
        rst            = 1'b1;
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata  = rep8(8'h93);
        step();
        bus.mem_rdata = rep8(8'h94);
        step();
        bus.mem_rvalid = 1'b0;
        step();
        chk_zero = 1'b0;
        step();

        // Line buffer: refill 0x60, drop the request, then ask for 0x7C in the same line.
        fill(32'h0000_0060, 32'h0000_0060, lb, 1, 2, 3, 4, 5, 0, 1'b1, 1'b0, 32'h0);
        fill(32'h0000_007C, 32'h0000_0060, lc, 1, 2, 3, 4, 5, 0, !LB_EN, 1'b0, 32'h0);
        repeat (3) step();

        chk_end = 1'b1;
        step();
        chk_end = 1'b0;
        step();
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule

// File: doc/icache_line_adapter.md
# icache_line_adapter

Bridges the instruction cache's 256-bit line-fill port to the 64-bit burst memory port. When the cache misses, the adapter issues one line-aligned burst read, packs the returned beats into a full line, and returns it with a single-cycle `pmem_resp` pulse. It sits directly downstream of the instruction cache, between the cache's `pmem_*` port and the memory arbiter.

## Interface
Parameters:
- `LINE_W`, default 256: cache line width in bits.
- `BEAT_W`, default 64: memory beat width in bits.
- `BEATS` (derived) = `LINE_W/BEAT_W`, which must be a power of two ≥2.
- `OFS` (derived) = `$clog2(LINE_W/8)`: byte-offset bits, forced to zero on the memory address.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `pmem_address` in 32: line address from the cache. Low `OFS` bits are ignored.
- `pmem_read` in 1: line-fill request. Level-held by the cache until it sees `pmem_resp`.
- `pmem_rdata` out `LINE_W`: assembled line.
- `pmem_resp` out 1: one-cycle pulse meaning the line is valid.
- `mem_address` out 32: burst start address, always `{pmem_address[31:OFS], OFS'b0}`.
- `mem_read` out 1: burst request, held until `mem_gnt`.
- `mem_gnt` in 1: memory accepted the request.
- `mem_rdata` in `BEAT_W`: beat data.
- `mem_rvalid` in 1: beat valid. Beats may have gaps and always arrive in ascending address order.

## Operation
- State machine: IDLE, REQ, BURST, RESP, DONE.
- IDLE:
  - If `pmem_read`=1, latch the line address into `addr_q` and go to REQ.
  - `mem_rvalid` arriving in IDLE is ignored.
- REQ:
  - `mem_read`=1 and `mem_address`=`addr_q`.
  - On `mem_gnt`=1: go to BURST and clear `beat_cnt`.
  - `mem_rvalid` in the same cycle as `mem_gnt` is legal and counts as beat 0.
- BURST:
  - Each `mem_rvalid` writes `mem_rdata` into `line_q[beat_cnt*BEAT_W +: BEAT_W]` and increments `beat_cnt`. The counter has width `$clog2(BEATS)` and wraps to 0.
  - On the beat with `beat_cnt==BEATS-1`, go to RESP.
- RESP:
  - `pmem_resp`=1 for exactly this one cycle. `pmem_rdata`=`line_q`.
  - Set `last_addr_q`=`addr_q` and `last_vld_q`=1, then go to DONE.
- DONE:
  - Exists because the cache may hold `pmem_read` high, with the same address, for one or more cycles after `pmem_resp` while its tag RAM updates.
  - Return to IDLE when `pmem_read`=0, or when `pmem_address[31:OFS]`≠`addr_q[31:OFS]`.
  - No new burst is issued while in DONE.
- `pmem_rdata` is driven from `line_q` at all times. It holds its value from RESP until the first beat of the next burst.
- `pmem_address` changing while in REQ or BURST is a protocol violation. The adapter keeps using `addr_q`.
- Reset values:
  - state=IDLE, `mem_read`=0, `pmem_resp`=0.
  - `line_q`=0, so `pmem_rdata`=0.
  - `beat_cnt`=0, `addr_q`=0, `last_vld_q`=0.
- Reset mid-burst returns to IDLE immediately. Beats still in flight are ignored, because `mem_rvalid` outside BURST/REQ is dropped.

## Timing
- Request latency: `pmem_read` rising in IDLE at cycle 0 produces `mem_read`=1 at cycle 1, driven from registered state.
- Response latency: a final beat at cycle N produces `pmem_resp` at cycle N+1.
- Minimum miss-to-response latency, with `mem_gnt` at cycle 1 and back-to-back beats from cycle 2: `pmem_resp` at cycle 2+`BEATS`, which is 6 for the defaults.
- All outputs are registered or decoded from state only. There are no combinational paths from `mem_*` inputs to `pmem_*` outputs.
- Earliest next request: the adapter returns to IDLE the cycle after it observes the DONE exit condition.
  - If `pmem_read` stays high with a new address, that request is latched one cycle after the DONE exit.

## Configuration
- `ICACHE_ADAPTER_LINE_BUF_EN` defined:
  - In IDLE, if `pmem_read`=1, `last_vld_q`=1 and `pmem_address[31:OFS]`==`last_addr_q[31:OFS]`, go straight to RESP. `pmem_resp` pulses at cycle 1, `mem_read` stays 0, and `pmem_rdata`=`line_q` unchanged.
  - On any reset, `last_vld_q` is cleared.
- `ICACHE_ADAPTER_LINE_BUF_EN` undefined:
  - `last_addr_q` and `last_vld_q` are not implemented.
  - Every IDLE request performs a full burst.

## Test plan
- **Basic fill:** `pmem_read`=1 with `pmem_address`=0x0000_0064; `mem_gnt` at cycle 1; beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 at cycles 2–5.
  - `mem_address`=0x0000_0060.
  - `pmem_resp` is high at cycle 6 only.
  - `pmem_rdata`={0x44..44, 0x33..33, 0x22..22, 0x11..11}.
- **Gapped beats and delayed grant:** `mem_gnt` at cycle 4; beats at cycles 5, 8, 9, 12.
  - `mem_read` is high for cycles 1–4.
  - `pmem_resp` at cycle 13.
  - Data is packed in arrival order.
- **Held request after response:** `pmem_read` stays high with the same address for 3 cycles after `pmem_resp`.
  - No second `mem_read` is issued.
  - After `pmem_read` drops, a request to 0x80 starts a new burst with `mem_address`=0x80.
- **Reset during BURST:** assert `rst`=0 after beat 1, release it, then send two stray beats.
  - All outputs are 0, state is IDLE, and `pmem_resp` never pulses.
- **Line buffer, with `ICACHE_ADAPTER_LINE_BUF_EN`:** fill 0x60, then drop `pmem_read`, then request 0x7C.
  - `pmem_resp` at cycle 1, with no `mem_read` and the same line data.
  - Without the macro, the same stimulus produces a full burst.
- **Back-to-back different lines:** `pmem_read` stays high while the address switches from 0x60 to 0xA0 in DONE.
  - Exactly two bursts occur, with `mem_address` 0x60 then 0xA0.
  - Two `pmem_resp` pulses occur.
